// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit scheduler: FSM state codes, CR/LF bytes,
// and the bit period used by uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_DONE = 3'd3,
        CRLF_CR   = 3'd4,
        CRLF_LF   = 3'd5,
        RELEASE   = 3'd6
    } sched_state_e;

    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam int         CLKS_PER_BIT = 434;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request found
// searching upward from ptr_i+1 with wrap, plus the index of that requester.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o
);

    logic             found;
    logic [PTR_W-1:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Message-granular round-robin sharing of one uart_tx between NUM_REQ byte streams.
// Define UART_SCHED_CRLF_EN to append CR LF after the last byte of every message.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DONE_TIMEOUT = 8192,
    parameter int TO_W         = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_activate,
    output logic [7:0]           tx_data,
    input  logic                 tx_active,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 fault
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    sched_state_e       state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, arb_gnt;
    logic [PTR_W-1:0]   rr_q, rr_d, arb_idx;
    logic [7:0]         tx_data_q, tx_data_d, sel_data;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               tx_activate_q, busy_q, fault_q, fault_d;
    logic               done_q, last_q, last_d;
    logic               sel_valid, sel_last, done_rise;

`ifdef UART_SCHED_CRLF_EN
    typedef enum logic [1:0] {TAIL_NONE, TAIL_CR, TAIL_LF} tail_e;
    tail_e tail_q, tail_d;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // rr_q always holds the index of the current owner, so it doubles as the mux select
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_q == PTR_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    assign done_rise = tx_done & ~done_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        fault_d   = fault_q;
        to_cnt_d  = to_cnt_q;
`ifdef UART_SCHED_CRLF_EN
        tail_d    = tail_q;
`endif
        case (state_q)
            IDLE: begin
                // uart_tx has no reset, so a frame left over from before reset blocks us
                if ((|req_valid) && !tx_active) begin
                    grant_d = arb_gnt;
                    rr_d    = arb_idx;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (sel_valid) begin
                    tx_data_d = sel_data;
                    last_d    = sel_last;
`ifdef UART_SCHED_CRLF_EN
                    tail_d    = TAIL_NONE;
`endif
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                to_cnt_d = '0;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_rise) begin
`ifdef UART_SCHED_CRLF_EN
                    case (tail_q)
                        TAIL_CR: state_d = CRLF_LF;
                        TAIL_LF: state_d = RELEASE;
                        default: state_d = last_q ? CRLF_CR : FETCH;
                    endcase
`else
                    state_d = last_q ? RELEASE : FETCH;
`endif
                end else if (to_cnt_q == TO_W'(DONE_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = RELEASE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
`ifdef UART_SCHED_CRLF_EN
            CRLF_CR: begin
                tx_data_d = ASCII_CR;
                tail_d    = TAIL_CR;
                state_d   = LAUNCH;
            end
            CRLF_LF: begin
                tx_data_d = ASCII_LF;
                tail_d    = TAIL_LF;
                state_d   = LAUNCH;
            end
`endif
            RELEASE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_q          <= PTR_W'(NUM_REQ - 1);
            tx_data_q     <= 8'h00;
            tx_activate_q <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
            done_q        <= 1'b0;
            last_q        <= 1'b0;
            to_cnt_q      <= '0;
`ifdef UART_SCHED_CRLF_EN
            tail_q        <= TAIL_NONE;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_q          <= rr_d;
            tx_data_q     <= tx_data_d;
            tx_activate_q <= (state_d == LAUNCH);
            busy_q        <= (state_d != IDLE);
            fault_q       <= fault_d;
            done_q        <= tx_done;
            last_q        <= last_d;
            to_cnt_q      <= to_cnt_d;
`ifdef UART_SCHED_CRLF_EN
            tail_q        <= tail_d;
`endif
        end
    end

    assign req_ready   = (state_q == FETCH) ? grant_q : '0;
    assign grant       = grant_q;
    assign tx_activate = tx_activate_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: requester drivers, a fast uart_tx model,
// and a message-level round-robin reference model (CR LF tail when UART_SCHED_CRLF_EN).
module tb_uart_tx_scheduler;

    localparam int NUM_REQ      = 2;
    localparam int DONE_TIMEOUT = 8192;
    localparam int TO_W         = 14;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_activate;
    logic [7:0]           tx_data;
    logic                 tx_active = 1'b0;
    logic                 tx_done = 1'b0;
    logic                 busy;
    logic                 fault;

    uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .DONE_TIMEOUT(DONE_TIMEOUT), .TO_W(TO_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_activate (tx_activate),
        .tx_data     (tx_data),
        .tx_active   (tx_active),
        .tx_done     (tx_done),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         gap;
    } item_t;

    item_t      drv_q[NUM_REQ][$];
    logic [7:0] mq_d[NUM_REQ][$];
    logic       mq_l[NUM_REQ][$];
    int         rr_m = NUM_REQ - 1;

    logic [7:0]         exp_q[$];
    logic [7:0]         sent_q[$];
    logic [NUM_REQ-1:0] gnt_act_q[$];
    int                 act_cyc_q[$];
    int                 done_cyc_q[$];
    int                 act_cnt = 0;
    int                 present_cyc[NUM_REQ];

    logic [NUM_REQ-1:0]   hs = '0;
    logic [NUM_REQ-1:0]   prev_v = '0;
    logic [NUM_REQ-1:0]   dv;
    logic [8*NUM_REQ-1:0] dd;
    logic [NUM_REQ-1:0]   dl;
    item_t                dit;

    bit no_done = 1'b0;
    int force_len = 0;
    int left = 0;
    int dcnt = 0;

    // Requester drivers: pop the byte handshaken at the last edge, present the next
    always @(negedge clk) begin
        dv = '0; dd = '0; dl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            if (drv_q[i].size() > 0) begin
                dit = drv_q[i][0];
                if (dit.gap > 0) begin
                    dit.gap = dit.gap - 1;
                    drv_q[i][0] = dit;
                end else begin
                    dv[i] = 1'b1;
                    dd[8*i +: 8] = dit.d;
                    dl[i] = dit.l;
                end
            end
            if (dv[i] && !prev_v[i]) present_cyc[i] = cyc;
        end
        req_valid = dv;
        req_data  = dd;
        req_last  = dl;
        prev_v    = dv;
        hs        = dv & req_ready;
    end

    // uart_tx model and line monitor; tx_done is held for two cycles
    always @(negedge clk) begin
        if (tx_activate) begin
            sent_q.push_back(tx_data);
            gnt_act_q.push_back(grant);
            act_cyc_q.push_back(cyc);
            act_cnt   = act_cnt + 1;
            tx_active = 1'b1;
            tx_done   = 1'b0;
            dcnt      = 0;
            left      = (force_len > 0) ? force_len : int'($urandom_range(16, 4));
        end else if (tx_active) begin
            if (left > 1) left = left - 1;
            else begin
                tx_active = 1'b0;
                if (!no_done) begin
                    tx_done = 1'b1;
                    dcnt    = 2;
                    done_cyc_q.push_back(cyc);
                end
            end
        end else if (dcnt > 0) begin
            dcnt = dcnt - 1;
            if (dcnt == 0) tx_done = 1'b0;
        end
    end

    task automatic push_byte(input int r, input logic [7:0] d, input logic l, input int gap, input bit to_model);
        item_t it;
        it.d = d; it.l = l; it.gap = gap;
        drv_q[r].push_back(it);
        if (to_model) begin
            mq_d[r].push_back(d);
            mq_l[r].push_back(l);
        end
    endtask

    // Reference: whole messages, owner chosen as next pending requester after the last owner
    task automatic model_run();
        bit   any;
        int   j;
        logic lst;
        do begin
            any = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                j = (rr_m + k) % NUM_REQ;
                if (!any && mq_d[j].size() > 0) begin
                    any  = 1'b1;
                    rr_m = j;
                    do begin
                        exp_q.push_back(mq_d[j].pop_front());
                        lst = mq_l[j].pop_front();
                    end while (!lst);
`ifdef UART_SCHED_CRLF_EN
                    exp_q.push_back(8'h0D);
                    exp_q.push_back(8'h0A);
`endif
                end
            end
        end while (any);
    endtask

    task automatic clear_logs();
        exp_q.delete(); sent_q.delete(); gnt_act_q.delete();
        act_cyc_q.delete(); done_cyc_q.delete();
    endtask

    function automatic bit drv_empty();
        for (int i = 0; i < NUM_REQ; i++) if (drv_q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_quiet(input string name);
        int n = 0;
        while (!(sent_q.size() >= exp_q.size() && drv_empty() && busy === 1'b0
                 && !tx_active && !tx_done) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            checks++; errors++;
            $display("FAIL %s_quiet: scheduler still busy after %0d cycles (sent %0d, required %0d)",
                     name, n, sent_q.size(), exp_q.size());
        end
    endtask

    task automatic compare_sent(input string name);
        checks++;
        if (sent_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: %0d bytes sent, required %0d", name, sent_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
            checks++;
            if (sent_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h, required %h", name, i, sent_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (grant !== '0 || req_ready !== '0 || tx_activate !== 1'b0 || tx_data !== 8'h00
            || busy !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL %s: grant=%b ready=%b act=%b data=%h busy=%b fault=%b, required all zero",
                     name, grant, req_ready, tx_activate, tx_data, busy, fault);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_hold");
        @(posedge clk); #2 rst_n = 1'b1;
        rr_m = NUM_REQ - 1;
        @(negedge clk);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_contention();
        clear_logs();
        @(posedge clk);
        push_byte(0, 8'h10, 1'b0, 0, 1'b1); push_byte(0, 8'h11, 1'b1, 0, 1'b1);
        push_byte(1, 8'h20, 1'b0, 0, 1'b1); push_byte(1, 8'h21, 1'b1, 0, 1'b1);
        model_run();
        wait_quiet("contention");
        compare_sent("contention");
        checks++;
        if (gnt_act_q.size() == 0 || gnt_act_q[0] !== 2'b01) begin
            errors++;
            $display("FAIL contention_first_owner: got %b, required 01",
                     gnt_act_q.size() ? gnt_act_q[0] : 2'bxx);
        end
        clear_logs();
        @(posedge clk);
        push_byte(0, 8'h30, 1'b1, 0, 1'b1);
        push_byte(1, 8'h31, 1'b1, 0, 1'b1);
        model_run();
        wait_quiet("retie");
        compare_sent("retie");
    endtask

    task automatic test_single();
        int a0;
        clear_logs();
        a0 = act_cnt;
        @(posedge clk);
        push_byte(0, 8'h41, 1'b0, 0, 1'b1);
        push_byte(0, 8'h42, 1'b1, 0, 1'b1);
        model_run();
        wait_quiet("single");
        compare_sent("single");
        checks++;
        if (act_cnt - a0 !== exp_q.size()) begin
            errors++;
            $display("FAIL single_pulses: %0d activations, required %0d", act_cnt - a0, exp_q.size());
        end
        checks++;
        if (grant !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: grant=%b busy=%b, required 00 0", grant, busy);
        end
        checks++;
        if (act_cyc_q.size() < 2 || act_cyc_q[0] - present_cyc[0] !== 2) begin
            errors++;
            $display("FAIL single_launch_latency: got %0d, required 2",
                     act_cyc_q.size() ? act_cyc_q[0] - present_cyc[0] : -1);
        end
        checks++;
        if (act_cyc_q.size() < 2 || done_cyc_q.size() < 1 || act_cyc_q[1] - done_cyc_q[0] !== 2) begin
            errors++;
            $display("FAIL single_next_byte_latency: got %0d, required 2",
                     (act_cyc_q.size() > 1 && done_cyc_q.size() > 0) ? act_cyc_q[1] - done_cyc_q[0] : -1);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        int a0;
        clear_logs();
        @(posedge clk);
        push_byte(1, 8'hA0, 1'b0, 0, 1'b1);
        push_byte(1, 8'hA1, 1'b0, 1000, 1'b1);
        push_byte(1, 8'hA2, 1'b1, 0, 1'b1);
        model_run();
        while (grant !== 2'b10 && n < 100) begin @(negedge clk); n++; end
        push_byte(0, 8'hB0, 1'b0, 0, 1'b1);
        push_byte(0, 8'hB1, 1'b1, 0, 1'b1);
        model_run();
        repeat (100) @(negedge clk);
        a0 = act_cnt;
        repeat (700) @(negedge clk);
        checks++;
        if (act_cnt !== a0) begin
            errors++;
            $display("FAIL stall_no_launch: %0d activations during stall, required 0", act_cnt - a0);
        end
        checks++;
        if (grant !== 2'b10) begin
            errors++;
            $display("FAIL stall_grant_held: grant=%b, required 10", grant);
        end
        wait_quiet("stall");
        compare_sent("stall");
    endtask

    task automatic test_timeout();
        int n = 0;
        int dt;
        clear_logs();
        no_done = 1'b1;
        @(posedge clk);
        push_byte(0, 8'h77, 1'b1, 0, 1'b0);
        exp_q.push_back(8'h77);
        rr_m = 0;
        while (fault !== 1'b1 && n < DONE_TIMEOUT + 500) begin @(negedge clk); n++; end
        dt = act_cyc_q.size() ? cyc - act_cyc_q[0] : -1;
        checks++;
        if (fault !== 1'b1 || dt < DONE_TIMEOUT - 1 || dt > DONE_TIMEOUT + 2) begin
            errors++;
            $display("FAIL timeout_fault_time: fault=%b after %0d cycles, required 1 near %0d",
                     fault, dt, DONE_TIMEOUT);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (grant !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release: grant=%b busy=%b, required 00 0", grant, busy);
        end
        no_done = 1'b0;
        compare_sent("timeout");
        clear_logs();
        @(posedge clk);
        push_byte(1, 8'h5A, 1'b1, 0, 1'b1);
        model_run();
        wait_quiet("after_fault");
        compare_sent("after_fault");
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky: fault=%b, required 1", fault);
        end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        int bad = 0;
        clear_logs();
        force_len = 300;
        @(posedge clk);
        push_byte(0, 8'h66, 1'b1, 0, 1'b0);
        while (!tx_active && n < 100) begin @(negedge clk); n++; end
        force_len = 0;
        repeat (10) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        @(posedge clk); #2 rst_n = 1'b1;
        rr_m = NUM_REQ - 1;
        clear_logs();
        push_byte(1, 8'h67, 1'b1, 0, 1'b1);
        model_run();
        n = 0;
        while (tx_active && n < 400) begin
            @(negedge clk);
            n++;
            if (tx_activate) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL midframe_no_launch: %0d activations while uart busy, required 0", bad);
        end
        wait_quiet("midframe");
        compare_sent("midframe");
    endtask

    task automatic test_tail();
        clear_logs();
        @(posedge clk);
        push_byte(0, 8'h55, 1'b1, 0, 1'b1);
        model_run();
        wait_quiet("tail");
        compare_sent("tail");
        checks++;
        if (gnt_act_q.size() != exp_q.size() || gnt_act_q[gnt_act_q.size()-1] !== 2'b01) begin
            errors++;
            $display("FAIL tail_grant_held: grant at final launch=%b, required 01",
                     gnt_act_q.size() ? gnt_act_q[gnt_act_q.size()-1] : 2'bxx);
        end
    endtask

    task automatic test_random();
        int nm, len;
        for (int round = 0; round < 3; round++) begin
            clear_logs();
            @(posedge clk);
            for (int r = 0; r < NUM_REQ; r++) begin
                nm = $urandom_range(2, 1);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(3, 1);
                    for (int b = 0; b < len; b++)
                        push_byte(r, 8'($urandom), (b == len - 1), (b == 0) ? 0 : int'($urandom_range(3, 0)), 1'b1);
                end
            end
            model_run();
            wait_quiet("random");
            compare_sent("random");
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_stall();
        test_tail();
        test_random();
        test_timeout();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
